// File: rtl/sqrd_pivot_select_pkg.sv
// sqrd_pivot_select_pkg: shared constants, types and helpers for the sorted-QR pivot stage.
//
// Contents:
//   NCOL, IDX_WL, NORM_WL   column count, index width and norm width.
//   PERM_ID                 identity permutation; field i holds i.
//   LAST_STEP               index of the final explicit step (column 7 is implicit).
//   state_e                 pivot FSM states.
//   cand_t / cand_min       argmin tree node and its merge function.
//
// The shared width constants normally come from parameters.v. The defaults below apply only
// when that file has not already defined them.
//
// Optional feature: SQRD_NEG_CLAMP_EN (see sqrd_pivot_select.sv).

`ifndef COLNORM_WL
`define COLNORM_WL 16
`endif
`ifndef COLNORM_FWL
`define COLNORM_FWL 8
`endif
`ifndef WL
`define WL 16
`endif
`ifndef PIV_IDX_WL
`define PIV_IDX_WL 3
`endif
`ifndef PERM_ID
`define PERM_ID 24'hFAC688
`endif

package sqrd_pivot_select_pkg;

  localparam int unsigned NCOL    = 8;
  localparam int unsigned IDX_WL  = `PIV_IDX_WL;
  localparam int unsigned NORM_WL = `COLNORM_WL;

  localparam logic [NCOL*IDX_WL-1:0] PERM_ID   = `PERM_ID;
  localparam logic [IDX_WL-1:0]      LAST_STEP = 3'd6;

  typedef enum logic [1:0] {StIdle, StCmp, StOut} state_e;

  typedef struct packed {
    logic                      vld;
    logic signed [NORM_WL-1:0] val;
    logic [IDX_WL-1:0]         idx;
  } cand_t;

  // 'a' is always the lower-index operand, so picking 'a' on equality gives lowest-index ties.
  function automatic cand_t cand_min(input cand_t a, input cand_t b);
    if (a.vld && (!b.vld || ($signed(a.val) <= $signed(b.val)))) begin
      cand_min = a;
    end else begin
      cand_min = b;
    end
  endfunction

endpackage

// File: rtl/sqrd_pivot_select_pivot_argmin8.sv
// pivot_argmin8: combinational 8-input signed argmin with per-column eligibility mask.
//
// Ports:
//   norms    packed signed norms, column i at bits [NORM_WL*i +: NORM_WL]
//   mask     1 = column eligible for selection
//   min_idx  index of the smallest eligible norm; lowest index wins ties; 0 if none eligible
//
// Structure: three levels of pairwise merges (8 -> 4 -> 2 -> 1).

module pivot_argmin8
  import sqrd_pivot_select_pkg::*;
(
  input  logic [NCOL*NORM_WL-1:0] norms,
  input  logic [NCOL-1:0]         mask,
  output logic [IDX_WL-1:0]       min_idx
);

  cand_t lvl0 [NCOL];
  cand_t lvl1 [4];
  cand_t lvl2 [2];
  cand_t root;

  always_comb begin
    for (int i = 0; i < NCOL; i++) begin
      lvl0[i].vld = mask[i];
      lvl0[i].val = norms[NORM_WL*i +: NORM_WL];
      lvl0[i].idx = IDX_WL'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = cand_min(lvl0[2*i], lvl0[2*i+1]);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = cand_min(lvl1[2*i], lvl1[2*i+1]);
    end
  end

  always_comb begin
    root    = cand_min(lvl2[0], lvl2[1]);
    min_idx = root.vld ? root.idx : '0;
  end

endmodule

// File: rtl/sqrd_pivot_select.sv
// sqrd_pivot_select: sorted-QR pivot stage for the real-valued 8x8 channel form.
//
// Picks the minimum-norm column among columns k..7, swaps its norm into position k and
// tracks the cumulative column permutation. One step per handshake, k = 0..6.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   in_valid_i      colnorm_i valid
//   in_ready_o      high while idle
//   first_i         on accept: step 0 and identity permutation (frame start/abort)
//   colnorm_i       packed signed norms, column i at [NORM_WL*i +: NORM_WL]
//   out_valid_o     result valid, held until out_ready_i
//   out_ready_i     downstream accepts
//   pivot_idx_o     selected column (k..7)
//   step_o          step this result belongs to
//   last_o          high with step 6
//   colnorm_o       input norms with entries k and pivot swapped
//   perm_o          permutation after this step; field i = original column at position i
//
// Optional feature: define SQRD_NEG_CLAMP_EN to replace negative norms with zero before the
// compare and in colnorm_o.

module sqrd_pivot_select
  import sqrd_pivot_select_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        first_i,
  input  logic [NCOL*`COLNORM_WL-1:0] colnorm_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [IDX_WL-1:0]           pivot_idx_o,
  output logic [IDX_WL-1:0]           step_o,
  output logic                        last_o,
  output logic [NCOL*`COLNORM_WL-1:0] colnorm_o,
  output logic [NCOL*IDX_WL-1:0]      perm_o
);

  state_e state_q, state_d;

  logic [IDX_WL-1:0]       k_q, keff_q, piv_q, step_q, piv_w;
  logic                    last_q, ov_q;
  logic [NCOL*NORM_WL-1:0] norm_q, cn_q, norm_eff, cn_sw;
  logic [NCOL*IDX_WL-1:0]  perm_q, perm_sw;
  logic [NCOL-1:0]         mask;
  logic                    accept, out_hs;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCmp;
      StCmp:   state_d = StOut;
      StOut:   if (out_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / handshake decode.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    accept      = in_valid_i & in_ready_o;
    out_hs      = (state_q == StOut) & ov_q & out_ready_i;
    out_valid_o = ov_q;
    pivot_idx_o = piv_q;
    step_o      = step_q;
    last_o      = last_q;
    colnorm_o   = cn_q;
    perm_o      = perm_q;
  end

  always_comb begin
    norm_eff = norm_q;
`ifdef SQRD_NEG_CLAMP_EN
    for (int i = 0; i < NCOL; i++) begin
      if (norm_q[NORM_WL*i+NORM_WL-1]) norm_eff[NORM_WL*i +: NORM_WL] = '0;
    end
`endif
  end

  // Columns already placed (index < keff) are never candidates.
  always_comb begin
    for (int i = 0; i < NCOL; i++) begin
      mask[i] = (IDX_WL'(i) >= keff_q);
    end
  end

  pivot_argmin8 u_argmin (
    .norms   (norm_eff),
    .mask    (mask),
    .min_idx (piv_w)
  );

  // When piv_w == keff_q both writes hit the same field with its own value: a no-op swap.
  always_comb begin
    cn_sw   = norm_eff;
    perm_sw = perm_q;
    cn_sw[NORM_WL*keff_q +: NORM_WL]  = norm_eff[NORM_WL*piv_w +: NORM_WL];
    cn_sw[NORM_WL*piv_w +: NORM_WL]   = norm_eff[NORM_WL*keff_q +: NORM_WL];
    perm_sw[IDX_WL*keff_q +: IDX_WL]  = perm_q[IDX_WL*piv_w +: IDX_WL];
    perm_sw[IDX_WL*piv_w +: IDX_WL]   = perm_q[IDX_WL*keff_q +: IDX_WL];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      keff_q <= '0;
      norm_q <= '0;
      perm_q <= PERM_ID;
      piv_q  <= '0;
      step_q <= '0;
      last_q <= 1'b0;
      cn_q   <= '0;
      ov_q   <= 1'b0;
    end else begin
      if (accept) begin
        norm_q <= colnorm_i;
        keff_q <= first_i ? '0 : k_q;
        if (first_i) perm_q <= PERM_ID;
      end
      if (state_q == StCmp) begin
        piv_q  <= piv_w;
        step_q <= keff_q;
        last_q <= (keff_q == LAST_STEP);
        cn_q   <= cn_sw;
        perm_q <= perm_sw;
        ov_q   <= 1'b1;
      end
      if (out_hs) begin
        ov_q <= 1'b0;
        if (last_q) begin
          k_q    <= '0;
          perm_q <= PERM_ID;
        end else begin
          k_q <= step_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrd_pivot_select.sv
// tb_sqrd_pivot_select: directed-vector bench for sqrd_pivot_select.
// Expected pivots, swapped norms and permutations are hand-computed constants.

`ifndef COLNORM_WL
`define COLNORM_WL 16
`endif

module tb_sqrd_pivot_select;

  localparam int W  = `COLNORM_WL;
  localparam int NW = 8 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          first_i = 1'b0;
  logic [NW-1:0] colnorm_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [2:0]    pivot_idx_o;
  logic [2:0]    step_o;
  logic          last_o;
  logic [NW-1:0] colnorm_o;
  logic [23:0]   perm_o;

  int n_vec  = 0;
  int n_miss = 0;

  sqrd_pivot_select dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .first_i     (first_i),
    .colnorm_i   (colnorm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pivot_idx_o (pivot_idx_o),
    .step_o      (step_o),
    .last_o      (last_o),
    .colnorm_o   (colnorm_o),
    .perm_o      (perm_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    int a[8];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    pk = '0;
    for (int i = 0; i < 8; i++) pk[W*i +: W] = a[i][W-1:0];
  endfunction

  function automatic logic [23:0] pp(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    int a[8];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    pp = '0;
    for (int i = 0; i < 8; i++) pp[3*i +: 3] = a[i][2:0];
  endfunction

  // Returns one cycle after the accepting edge (DUT in its compare cycle).
  task automatic send(input logic first, input logic [NW-1:0] norms);
    int n = 0;
    while (!in_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready_o, 1'b1);
    in_valid_i = 1'b1;
    first_i    = first;
    colnorm_i  = norms;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    first_i    = 1'b0;
  endtask

  task automatic step(input logic first, input logic [NW-1:0] norms, input int piv,
                      input int stp, input logic lst, input logic [NW-1:0] cn,
                      input logic [23:0] perm, input logic hs);
    send(first, norms);
    chk("valid_t1", out_valid_o, 1'b0);
    @(posedge clk); #1;
    chk("valid_t2", out_valid_o, 1'b1);
    chk("pivot", pivot_idx_o, piv);
    chk("step", step_o, stp);
    chk("last", last_o, lst);
    chk("colnorm", colnorm_o, cn);
    chk("perm", perm_o, perm);
    if (hs) begin
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      chk("valid_after_hs", out_valid_o, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_pivot", pivot_idx_o, 0);
    chk("rst_step", step_o, 0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_colnorm", colnorm_o, '0);
    chk("rst_perm", perm_o, 24'hFAC688);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame start, then k=1 with a tie at columns 3/4 and a smaller ignored c0.
    step(1'b1, pk(50, 40, 30, 20, 10, 60, 70, 80), 4, 0, 1'b0,
         pk(10, 40, 30, 20, 50, 60, 70, 80), pp(4, 1, 2, 3, 0, 5, 6, 7), 1'b1);
    step(1'b0, pk(1, 9, 9, 5, 5, 100, 100, 100), 3, 1, 1'b0,
         pk(1, 5, 9, 9, 5, 100, 100, 100), pp(4, 3, 2, 1, 0, 5, 6, 7), 1'b1);

    // k=2 with downstream stall; in_valid_i/first_i pulses during the stall must be ignored.
    step(1'b0, pk(0, 0, 7, 3, 8, 1, 2, 9), 5, 2, 1'b0,
         pk(0, 0, 1, 3, 8, 7, 2, 9), pp(4, 3, 5, 1, 0, 2, 6, 7), 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid_i = 1'b1;
      first_i    = 1'b1;
      colnorm_i  = pk(-9, -9, -9, -9, -9, -9, -9, -9);
      @(posedge clk); #1;
      chk("stall_valid", out_valid_o, 1'b1);
      chk("stall_in_ready", in_ready_o, 1'b0);
      chk("stall_pivot", pivot_idx_o, 5);
      chk("stall_colnorm", colnorm_o, pk(0, 0, 1, 3, 8, 7, 2, 9));
      chk("stall_perm", perm_o, pp(4, 3, 5, 1, 0, 2, 6, 7));
    end
    in_valid_i  = 1'b0;
    first_i     = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk("release_valid", out_valid_o, 1'b0);
    chk("release_in_ready", in_ready_o, 1'b1);

    // k=3, all norms zero: pivot stays at k.
    step(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0), 3, 3, 1'b0,
         pk(0, 0, 0, 0, 0, 0, 0, 0), pp(4, 3, 5, 1, 0, 2, 6, 7), 1'b1);

    // first_i mid-frame restarts from step 0 and identity.
    step(1'b1, pk(5, 1, 6, 6, 6, 6, 6, 6), 1, 0, 1'b0,
         pk(1, 5, 6, 6, 6, 6, 6, 6), pp(1, 0, 2, 3, 4, 5, 6, 7), 1'b1);

    // Reset while in the compare cycle: everything back to reset values, no output later.
    send(1'b0, pk(9, 9, 9, 9, 9, 9, 9, 9));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 1'b0);
    chk("midrst_in_ready", in_ready_o, 1'b1);
    chk("midrst_perm", perm_o, 24'hFAC688);
    chk("midrst_step", step_o, 0);
    chk("midrst_colnorm", colnorm_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst_quiet", out_valid_o, 1'b0);
    end

    // Full frame: equal norms for steps 0..5, step 6 picks column 7 over a smaller masked c0.
    for (int k = 0; k < 6; k++) begin
      step(1'b0, pk(42, 42, 42, 42, 42, 42, 42, 42), k, k, 1'b0,
           pk(42, 42, 42, 42, 42, 42, 42, 42), pp(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);
    end
    step(1'b0, pk(0, 42, 42, 42, 42, 42, 42, 1), 7, 6, 1'b1,
         pk(0, 42, 42, 42, 42, 42, 1, 42), pp(0, 1, 2, 3, 4, 5, 7, 6), 1'b1);
    chk("wrap_perm", perm_o, 24'hFAC688);
    step(1'b0, pk(42, 42, 42, 42, 42, 42, 42, 42), 0, 0, 1'b0,
         pk(42, 42, 42, 42, 42, 42, 42, 42), pp(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);

    // Negative norm at k=0.
`ifdef SQRD_NEG_CLAMP_EN
    step(1'b1, pk(-3, 2, 4, 4, 4, 4, 4, 4), 0, 0, 1'b0,
         pk(0, 2, 4, 4, 4, 4, 4, 4), pp(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);
`else
    step(1'b1, pk(-3, 2, 4, 4, 4, 4, 4, 4), 0, 0, 1'b0,
         pk(-3, 2, 4, 4, 4, 4, 4, 4), pp(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sqrd_pivot_select.md
Name: sqrd_pivot_select

Overview:
- Sorted-QR pivot stage of the 4x4 MIMO detector, operating on the real-valued 8x8 channel form.
- Sits directly downstream of the column-norm update stage. It consumes the packed 8-column norm vector and selects the minimum-norm column among the not-yet-processed columns k..7.
- Swaps that column's norm into position k and tracks the cumulative column permutation for the back end.
- Processes one step per handshake, k = 0..6; column 7 is implicit.

Parameters:
- NCOL, 8, number of real-valued columns; fixed at 8, with no other value supported.
- IDX_WL, 3, width of a column index.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid_i  in  1  colnorm_i valid
- in_ready_o  out  1  block can accept
- first_i  in  1  sampled on accept; forces k=0 and identity permutation (frame start/abort)
- colnorm_i  in  8*`COLNORM_WL  packed signed norms, column i at bits [`COLNORM_WL*i +: `COLNORM_WL]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- pivot_idx_o  out  IDX_WL  selected column index (k..7)
- step_o  out  IDX_WL  step k this result belongs to
- last_o  out  1  high with step_o==6
- colnorm_o  out  8*`COLNORM_WL  input norms with entries k and pivot swapped
- perm_o  out  8*IDX_WL  permutation after this step; field i = original column now at position i

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, k=0, out_valid_o=0.
  - pivot_idx_o=0, step_o=0, last_o=0, colnorm_o=0.
  - perm register = identity, so perm_o = 24'hFAC688 (fields 7..0 = 7..0).
  - in_ready_o=1.
- FSM IDLE -> CMP -> OUT -> IDLE:
  - in_ready_o = (state==IDLE).
  - Accept = in_valid_i & in_ready_o. On accept, register colnorm_i and the effective step keff (0 if first_i, else k); if first_i, also reset perm to identity. Then go to CMP.
  - CMP: compute the argmin, swap norms and perm, register all outputs, assert out_valid_o. Then go to OUT.
  - OUT: hold all outputs stable until out_valid_o & out_ready_i, then clear out_valid_o and go to IDLE.
- Latency and throughput:
  - Accept in cycle T gives out_valid_o high in T+2.
  - Minimum accept-to-accept spacing is 3 cycles.
- Step counter: k advances on the output handshake. After the step-6 handshake, k wraps to 0 and perm returns to identity.
- Argmin:
  - Signed compare over columns j >= keff; columns < keff are masked and never selected.
  - Ties go to the lowest index.
  - At keff=6 the compare covers only columns 6 and 7.
- Swap: if pivot==keff, colnorm_o equals the input and perm is unchanged.
- Arithmetic: no arithmetic on norms beyond compare and move. Widths are preserved exactly.
- Ignored inputs: first_i is ignored when there is no accept. in_valid_i is ignored outside IDLE.
- Reset mid-operation: returns to reset values immediately, and any in-flight step is discarded.

Optional Feature:
- Macro: SQRD_NEG_CLAMP_EN. It addresses norms driven slightly negative by truncation in the upstream subtraction.
- Defined: any negative norm is replaced by 0 before the compare and in colnorm_o.
- Undefined: raw signed values are compared and passed through unchanged.

Decomposition:
- The `COLNORM_WL, `COLNORM_FWL and `WL constants stay in the shared parameters.v.
- Add `PIV_IDX_WL=3 and `PERM_ID=24'hFAC688 to parameters.v.
- Sub-module pivot_argmin8: purely combinational 3-level compare tree with a per-column mask input and lowest-index tie-break; outputs the min index.
- The FSM, swap and perm logic stay in sqrd_pivot_select.

Test Plan:
- Reset then first_i=1, norms {c0..c7}={50,40,30,20,10,60,70,80}:
  - pivot=4, step=0, colnorm_o c0=10 and c4=50, perm_o fields 0 and 4 swapped (4 and 0).
  - out_valid_o is high 2 cycles after accept.
- Continue the frame with norms {x,9,9,5,5,100,100,100}, k=1:
  - pivot=3 (tie 3/4 resolved to the lowest index), perm field 1=3, field 3=1.
  - c0 is ignored even if it is smaller.
- Hold out_ready_i=0 for 5 cycles: outputs stay stable, in_ready_o=0, and in_valid_i pulses are ignored. Release: handshake, then IDLE.
- Run 7 steps with all norms equal: every pivot equals k, perm stays identity, last_o=1 only at step 6, then k=0 and perm_o=24'hFAC688.
- Assert first_i at step 3: k=0 and the permutation restarts from identity. Assert rst_n=0 in CMP: out_valid_o=0 immediately, no output on release.
- With SQRD_NEG_CLAMP_EN, norms {-3,2,...} at k=0: pivot=0 and colnorm_o c0=0. Without the macro: pivot=0 and c0=-3.
